// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Writeback merge stage in front of the register file write port.
//            Arbitrates the in-order pipeline writeback against long-latency
//            results (load/mul/div), buffers the latter in a small FIFO, drives
//            a registered write port and publishes a pending-destination mask.
// Options  : WB_STARVE_CNT_EN - adds a 32-bit counter of pipe_stall cycles.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int RF_NUM     = 32,
    parameter int DEPTH      = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pipe_valid,
    input  logic [$clog2(RF_NUM)-1:0] pipe_rd,
    input  logic [DATA_W-1:0]         pipe_data,
    output logic                      pipe_stall,
    input  logic                      lsu_valid,
    output logic                      lsu_ready,
    input  logic [$clog2(RF_NUM)-1:0] lsu_rd,
    input  logic [DATA_W-1:0]         lsu_data,
    output logic [RF_NUM-1:0]         busy_mask,
    output logic                      regWriteEn,
    output logic [$clog2(RF_NUM)-1:0] rd_out,
    output logic [DATA_W-1:0]         regWriteData
`ifdef WB_STARVE_CNT_EN
    ,
    output logic [31:0]               starve_events
`endif
);

    localparam int c_RD_W  = $clog2(RF_NUM);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_SC_W  = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

    localparam logic [c_CNT_W-1:0] c_DEPTH      = c_CNT_W'(DEPTH);
    localparam logic [c_SC_W-1:0]  c_STARVE_LIM = c_SC_W'(STARVE_LIM);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR   = c_PTR_W'(DEPTH - 1);

    // FIFO storage and bookkeeping
    logic [c_RD_W-1:0]  r_fifo_rd   [DEPTH];
    logic [DATA_W-1:0]  r_fifo_data [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_SC_W-1:0]  r_starve_cnt;

    // Arbitration wires
    logic               w_empty;
    logic               w_full;
    logic               w_lsu_xfer;
    logic               w_starved;
    logic               w_sel_fifo;
    logic               w_sel_pipe;
    logic               w_sel_byp;
    logic               w_win_valid;
    logic [c_RD_W-1:0]  w_win_rd;
    logic [DATA_W-1:0]  w_win_data;
    logic               w_push;
    logic               w_pop;
    logic [c_SC_W-1:0]  w_starve_nxt;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST_PTR) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_DEPTH);
    assign lsu_ready  = ~w_full;
    assign w_lsu_xfer = lsu_valid & lsu_ready;

    // The FIFO head is forced out once it has lost enough consecutive rounds.
    assign w_starved  = (r_starve_cnt == c_STARVE_LIM) & ~w_empty;
    assign pipe_stall = w_starved;

    // Priority winner select: starved head, pipe, head, lsu bypass, idle.
    always_comb begin
        w_sel_fifo = 1'b0;
        w_sel_pipe = 1'b0;
        w_sel_byp  = 1'b0;
        w_win_rd   = '0;
        w_win_data = '0;
        if (w_starved) begin
            w_sel_fifo = 1'b1;
            w_win_rd   = r_fifo_rd[r_rd_ptr];
            w_win_data = r_fifo_data[r_rd_ptr];
        end else if (pipe_valid) begin
            w_sel_pipe = 1'b1;
            w_win_rd   = pipe_rd;
            w_win_data = pipe_data;
        end else if (!w_empty) begin
            w_sel_fifo = 1'b1;
            w_win_rd   = r_fifo_rd[r_rd_ptr];
            w_win_data = r_fifo_data[r_rd_ptr];
        end else if (w_lsu_xfer) begin
            w_sel_byp  = 1'b1;
            w_win_rd   = lsu_rd;
            w_win_data = lsu_data;
        end
    end

    assign w_win_valid = w_sel_fifo | w_sel_pipe | w_sel_byp;
    assign w_pop       = w_sel_fifo;
    // Results for x0 are swallowed here so they never occupy a slot.
    assign w_push      = w_lsu_xfer & ~w_sel_byp & (lsu_rd != '0);

    // Starvation counter: counts rounds the non-empty FIFO loses to the pipe.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (w_empty || w_pop) begin
            w_starve_nxt = '0;
        end else if (w_sel_pipe && (r_starve_cnt != c_STARVE_LIM)) begin
            w_starve_nxt = r_starve_cnt + c_SC_W'(1);
        end
    end

    // FIFO control state: pointers, occupancy, per-slot valid and starvation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid      <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= ptr_inc(r_rd_ptr);
            end
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= ptr_inc(r_wr_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO payload; slot contents are qualified by r_valid so no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= lsu_rd;
            r_fifo_data[r_wr_ptr] <= lsu_data;
        end
    end

    // Pending-destination mask over occupied slots; x0 is never reported.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i]) begin
                busy_mask[r_fifo_rd[i]] = 1'b1;
            end
        end
        busy_mask[0] = 1'b0;
    end

    // Registered register-file write port; one cycle after arbitration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regWriteEn   <= 1'b0;
            rd_out       <= '0;
            regWriteData <= '0;
        end else begin
            regWriteEn <= w_win_valid & (w_win_rd != '0);
            if (w_win_valid) begin
                rd_out       <= w_win_rd;
                regWriteData <= w_win_data;
            end
        end
    end

`ifdef WB_STARVE_CNT_EN
    // Free-running count of cycles in which the pipe was held off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_events <= '0;
        end else if (pipe_stall) begin
            starve_events <= starve_events + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Self-checking bench for wb_arbiter: directed scenarios plus a
//            randomized run against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int DATA_W     = 32;
    localparam int RF_NUM     = 32;
    localparam int DEPTH      = 2;
    localparam int STARVE_LIM = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic [31:0] busy_mask;
    logic        regWriteEn;
    logic [4:0]  rd_out;
    logic [31:0] regWriteData;
`ifdef WB_STARVE_CNT_EN
    logic [31:0] starve_events;
`endif

    always #5 clk = ~clk;

    wb_arbiter #(
        .DATA_W     (DATA_W),
        .RF_NUM     (RF_NUM),
        .DEPTH      (DEPTH),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pipe_valid   (pipe_valid),
        .pipe_rd      (pipe_rd),
        .pipe_data    (pipe_data),
        .pipe_stall   (pipe_stall),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .busy_mask    (busy_mask),
        .regWriteEn   (regWriteEn),
        .rd_out       (rd_out),
        .regWriteData (regWriteData)
`ifdef WB_STARVE_CNT_EN
        ,
        .starve_events(starve_events)
`endif
    );

    // Reference model state: pending long-latency results in arrival order.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    int          mstarve;
    int          mstall_cnt;
    logic        e_stall, e_ready, e_we;
    logic [31:0] e_mask;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic model_reset();
        mq.delete();
        mstarve    = 0;
        mstall_cnt = 0;
    endtask

    // Drive one cycle of inputs (called at posedge+1), advance the model and
    // leave the expected values in e_*; returns mid-cycle for sampling.
    task automatic run_cycle(input logic pv, input logic [4:0] prd, input logic [31:0] pdata,
                             input logic lv, input logic [4:0] lrd, input logic [31:0] ldata);
        bit   won, popped, pipe_won, bypass, xfer;
        ent_t w;
        int   sz;
        pipe_valid = pv;  pipe_rd = prd;  pipe_data = pdata;
        lsu_valid  = lv;  lsu_rd  = lrd;  lsu_data  = ldata;
        sz      = mq.size();
        e_ready = (sz < DEPTH);
        e_stall = (mstarve == STARVE_LIM) && (sz > 0);
        e_mask  = '0;
        foreach (mq[i]) e_mask[mq[i].rd] = 1'b1;
        xfer = lv && e_ready;
        won = 0; popped = 0; pipe_won = 0; bypass = 0;
        w = '0;
        if (e_stall) begin
            w = mq.pop_front(); won = 1; popped = 1;
        end else if (pv) begin
            w = '{prd, pdata}; won = 1; pipe_won = 1;
        end else if (sz > 0) begin
            w = mq.pop_front(); won = 1; popped = 1;
        end else if (xfer) begin
            w = '{lrd, ldata}; won = 1; bypass = 1;
        end
        if (sz == 0 || popped) mstarve = 0;
        else if (pipe_won && mstarve < STARVE_LIM) mstarve++;
        if (xfer && !bypass && lrd != 5'd0) mq.push_back('{lrd, ldata});
        if (e_stall) mstall_cnt++;
        e_we   = won && (w.rd != 5'd0);
        e_rd   = w.rd;
        e_data = w.data;
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (regWriteEn !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %0b exp 0", regWriteEn); end
        n_tests++; if (rd_out !== 5'd0) begin n_fail++; $display("FAIL rst_rd: got %0d exp 0", rd_out); end
        n_tests++; if (regWriteData !== 32'd0) begin n_fail++; $display("FAIL rst_data: got %0h exp 0", regWriteData); end
        n_tests++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b exp 0", pipe_stall); end
        #2 reset = 1'b1;
        tick();
        n_tests++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b exp 1", lsu_ready); end
        n_tests++; if (busy_mask !== 32'd0) begin n_fail++; $display("FAIL rst_mask: got %0h exp 0", busy_mask); end
        n_tests++; if (regWriteEn !== 1'b0) begin n_fail++; $display("FAIL rel_we: got %0b exp 0", regWriteEn); end
`ifdef WB_STARVE_CNT_EN
        n_tests++; if (starve_events !== 32'd0) begin n_fail++; $display("FAIL rst_sev: got %0d exp 0", starve_events); end
`endif
    endtask

    task automatic test_single_write();
        run_cycle(1, 5'd5, 32'hA5A5_0001, 0, 5'd0, 32'd0);
        tick();
        n_tests++; if (regWriteEn !== 1'b1) begin n_fail++; $display("FAIL t2_we: got %0b exp 1", regWriteEn); end
        n_tests++; if (rd_out !== 5'd5) begin n_fail++; $display("FAIL t2_rd: got %0d exp 5", rd_out); end
        n_tests++; if (regWriteData !== 32'hA5A5_0001) begin n_fail++; $display("FAIL t2_data: got %0h exp a5a50001", regWriteData); end
        run_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        tick();
        n_tests++; if (regWriteEn !== 1'b0) begin n_fail++; $display("FAIL t2_we_off: got %0b exp 0", regWriteEn); end
    endtask

    task automatic test_starvation();
        run_cycle(1, 5'd10, 32'd100, 1, 5'd7, 32'h77);
        tick();
        n_tests++; if (rd_out !== 5'd10) begin n_fail++; $display("FAIL t3_rd0: got %0d exp 10", rd_out); end
        for (int k = 1; k <= 4; k++) begin
            run_cycle(1, 5'(10 + k), 32'(100 + k), 0, 5'd0, 32'd0);
            n_tests++; if (busy_mask[7] !== 1'b1) begin n_fail++; $display("FAIL t3_mask c%0d: got %0b exp 1", k, busy_mask[7]); end
            n_tests++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL t3_stall c%0d: got %0b exp 0", k, pipe_stall); end
            tick();
            n_tests++; if (rd_out !== 5'(10 + k)) begin n_fail++; $display("FAIL t3_rd c%0d: got %0d exp %0d", k, rd_out, 10 + k); end
        end
        run_cycle(1, 5'd15, 32'd105, 0, 5'd0, 32'd0);
        n_tests++; if (pipe_stall !== 1'b1) begin n_fail++; $display("FAIL t3_stall5: got %0b exp 1", pipe_stall); end
        tick();
        n_tests++; if (regWriteEn !== 1'b1 || rd_out !== 5'd7 || regWriteData !== 32'h77)
            begin n_fail++; $display("FAIL t3_pop: got we=%0b rd=%0d d=%0h exp we=1 rd=7 d=77", regWriteEn, rd_out, regWriteData); end
        run_cycle(1, 5'd15, 32'd105, 0, 5'd0, 32'd0);
        n_tests++; if (busy_mask[7] !== 1'b0 || pipe_stall !== 1'b0)
            begin n_fail++; $display("FAIL t3_after: got mask7=%0b stall=%0b exp 0 0", busy_mask[7], pipe_stall); end
        tick();
        n_tests++; if (rd_out !== 5'd15 || regWriteData !== 32'd105)
            begin n_fail++; $display("FAIL t3_held: got rd=%0d d=%0d exp rd=15 d=105", rd_out, regWriteData); end
    endtask

    task automatic test_fifo_full();
        run_cycle(1, 5'd20, 32'd200, 1, 5'd3, 32'd33);
        n_tests++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL t4_rdy0: got %0b exp 1", lsu_ready); end
        tick();
        run_cycle(1, 5'd21, 32'd201, 1, 5'd4, 32'd44);
        n_tests++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL t4_rdy1: got %0b exp 1", lsu_ready); end
        tick();
        run_cycle(1, 5'd22, 32'd202, 1, 5'd9, 32'd99);
        n_tests++; if (lsu_ready !== 1'b0) begin n_fail++; $display("FAIL t4_full: got %0b exp 0", lsu_ready); end
        n_tests++; if (busy_mask !== 32'h18) begin n_fail++; $display("FAIL t4_mask: got %0h exp 18", busy_mask); end
        tick();
        run_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        tick();
        n_tests++; if (rd_out !== 5'd3 || regWriteData !== 32'd33)
            begin n_fail++; $display("FAIL t4_pop3: got rd=%0d d=%0d exp rd=3 d=33", rd_out, regWriteData); end
        run_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        tick();
        n_tests++; if (rd_out !== 5'd4 || regWriteData !== 32'd44)
            begin n_fail++; $display("FAIL t4_pop4: got rd=%0d d=%0d exp rd=4 d=44", rd_out, regWriteData); end
        run_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        n_tests++; if (busy_mask !== 32'd0) begin n_fail++; $display("FAIL t4_drained: got %0h exp 0", busy_mask); end
        tick();
        n_tests++; if (regWriteEn !== 1'b0) begin n_fail++; $display("FAIL t4_no9: got %0b exp 0", regWriteEn); end
    endtask

    task automatic test_rd_zero();
        run_cycle(0, 5'd0, 32'd0, 1, 5'd0, 32'hDEAD);
        tick();
        n_tests++; if (regWriteEn !== 1'b0) begin n_fail++; $display("FAIL t5_byp0: got %0b exp 0", regWriteEn); end
        run_cycle(1, 5'd6, 32'd66, 1, 5'd0, 32'hBEEF);
        tick();
        n_tests++; if (regWriteEn !== 1'b1 || rd_out !== 5'd6)
            begin n_fail++; $display("FAIL t5_pipe: got we=%0b rd=%0d exp we=1 rd=6", regWriteEn, rd_out); end
        run_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        n_tests++; if (busy_mask !== 32'd0 || lsu_ready !== 1'b1)
            begin n_fail++; $display("FAIL t5_nofill: got mask=%0h rdy=%0b exp 0 1", busy_mask, lsu_ready); end
        tick();
        n_tests++; if (regWriteEn !== 1'b0) begin n_fail++; $display("FAIL t5_nodrain: got %0b exp 0", regWriteEn); end
        run_cycle(1, 5'd0, 32'd55, 0, 5'd0, 32'd0);
        tick();
        n_tests++; if (regWriteEn !== 1'b0) begin n_fail++; $display("FAIL t5_pipe0: got %0b exp 0", regWriteEn); end
    endtask

    task automatic test_random();
        logic        hold = 1'b0;
        logic [4:0]  hrd = '0;
        logic [31:0] hdata = '0;
        logic        pv, lv;
        logic [4:0]  prd, lrd;
        logic [31:0] pdata, ldata;
        for (int c = 0; c < 600; c++) begin
            if (hold) begin
                pv = 1'b1; prd = hrd; pdata = hdata;
            end else begin
                pv = ($urandom_range(0, 9) < 7); prd = 5'($urandom_range(0, 31)); pdata = $urandom;
            end
            lv = ($urandom_range(0, 9) < 5); lrd = 5'($urandom_range(0, 31)); ldata = $urandom;
            run_cycle(pv, prd, pdata, lv, lrd, ldata);
            n_tests++; if (pipe_stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall c%0d: got %0b exp %0b", c, pipe_stall, e_stall); end
            n_tests++; if (lsu_ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready c%0d: got %0b exp %0b", c, lsu_ready, e_ready); end
            n_tests++; if (busy_mask !== e_mask) begin n_fail++; $display("FAIL rnd_mask c%0d: got %0h exp %0h", c, busy_mask, e_mask); end
            hold = e_stall && pv; hrd = prd; hdata = pdata;
            tick();
            n_tests++; if (regWriteEn !== e_we) begin n_fail++; $display("FAIL rnd_we c%0d: got %0b exp %0b", c, regWriteEn, e_we); end
            if (e_we) begin
                n_tests++; if (rd_out !== e_rd || regWriteData !== e_data)
                    begin n_fail++; $display("FAIL rnd_wr c%0d: got rd=%0d d=%0h exp rd=%0d d=%0h", c, rd_out, regWriteData, e_rd, e_data); end
            end
        end
        for (int c = 0; c < DEPTH + 2; c++) begin
            run_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
            tick();
            n_tests++; if (regWriteEn !== e_we) begin n_fail++; $display("FAIL rnd_drain_we c%0d: got %0b exp %0b", c, regWriteEn, e_we); end
            if (e_we) begin
                n_tests++; if (rd_out !== e_rd || regWriteData !== e_data)
                    begin n_fail++; $display("FAIL rnd_drain c%0d: got rd=%0d exp rd=%0d", c, rd_out, e_rd); end
            end
        end
`ifdef WB_STARVE_CNT_EN
        n_tests++; if (starve_events !== 32'(mstall_cnt)) begin n_fail++; $display("FAIL rnd_sev: got %0d exp %0d", starve_events, mstall_cnt); end
`endif
    endtask

    task automatic test_reset_mid();
        run_cycle(1, 5'd1, 32'd11, 1, 5'd12, 32'd120);
        tick();
        run_cycle(1, 5'd2, 32'd22, 1, 5'd13, 32'd130);
        tick();
        run_cycle(1, 5'd3, 32'd33, 0, 5'd0, 32'd0);
        n_tests++; if (busy_mask !== 32'h3000) begin n_fail++; $display("FAIL t6_fill: got %0h exp 3000", busy_mask); end
        reset = 1'b0;
        #1;
        n_tests++; if (regWriteEn !== 1'b0 || rd_out !== 5'd0 || regWriteData !== 32'd0)
            begin n_fail++; $display("FAIL t6_async: got we=%0b rd=%0d d=%0h exp 0 0 0", regWriteEn, rd_out, regWriteData); end
        n_tests++; if (busy_mask !== 32'd0 || pipe_stall !== 1'b0 || lsu_ready !== 1'b1)
            begin n_fail++; $display("FAIL t6_state: got mask=%0h stall=%0b rdy=%0b exp 0 0 1", busy_mask, pipe_stall, lsu_ready); end
        pipe_valid = 1'b0; lsu_valid = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        model_reset();
`ifdef WB_STARVE_CNT_EN
        n_tests++; if (starve_events !== 32'd0) begin n_fail++; $display("FAIL t6_sev: got %0d exp 0", starve_events); end
`endif
        tick();
        for (int c = 0; c < 4; c++) begin
            run_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
            n_tests++; if (busy_mask !== 32'd0) begin n_fail++; $display("FAIL t6_mask c%0d: got %0h exp 0", c, busy_mask); end
            tick();
            n_tests++; if (regWriteEn !== 1'b0) begin n_fail++; $display("FAIL t6_nowrite c%0d: got %0b exp 0", c, regWriteEn); end
        end
    endtask

    initial begin
        reset      = 1'b0;
        pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
        lsu_valid  = 1'b0; lsu_rd  = '0; lsu_data  = '0;
        test_reset();
        test_single_write();
        test_starvation();
        test_fifo_full();
        test_rd_zero();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
